// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: shared FSM states, NAND opcodes and address-count helper
package nand_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_CE_SETUP, S_CMD0_LO, S_CMD0_HI, S_ADDR_LO, S_ADDR_HI,
        S_CMD1_LO, S_CMD1_HI, S_WAIT_WB, S_WAIT_RB, S_DONE
    } state_t;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_READ0  = 8'h00;
    localparam logic [7:0] CMD_READ1  = 8'h30;
    localparam logic [7:0] CMD_PROG0  = 8'h80;
    localparam logic [7:0] CMD_PROG1  = 8'h10;
    localparam logic [7:0] CMD_ERASE0 = 8'h60;
    localparam logic [7:0] CMD_ERASE1 = 8'hD0;
    localparam int MAX_ADDR_BYTES = 5;

    function automatic logic [2:0] clamp_naddr(input logic [2:0] n);
        return (n > 3'(MAX_ADDR_BYTES)) ? 3'(MAX_ADDR_BYTES) : n;
    endfunction

endpackage

// File: rtl/nand_rb_sync.sv
// nand_rb_sync: two-flop synchronizer for the asynchronous ready/busy lines
module nand_rb_sync #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_rb,
    output logic [W-1:0] o_rb
);

    logic [W-1:0] r_meta;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            o_rb   <= '0;
        end else begin
            r_meta <= i_rb;
            o_rb   <= r_meta;
        end
    end

endmodule

// File: rtl/nand_cmd_sequencer.sv
// nand_cmd_sequencer: issues cmd0 / address bytes / cmd1 on the async NAND bus, optional RB wait.
// Define NAND_SEQ_TIMEOUT_EN to bound the ready/busy wait by TIMEOUT_CYCLES.
module nand_cmd_sequencer
    import nand_seq_pkg::*;
#(
    parameter int NUM_CE         = 8,
    parameter int T_CS           = 2,
    parameter int T_WP           = 2,
    parameter int T_WH           = 2,
    parameter int T_WB           = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_chip,
    input  logic [7:0]        req_cmd0,
    input  logic [2:0]        req_naddr,
    input  logic [39:0]       req_addr,
    input  logic              req_has_cmd1,
    input  logic [7:0]        req_cmd1,
    input  logic              req_wait_rb,
    output logic              done_valid,
    output logic [2:0]        done_chip,
    output logic              done_status,
    output logic [NUM_CE-1:0] nand_cen,
    output logic              nand_cle,
    output logic              nand_ale,
    output logic              nand_wen,
    output logic              nand_wpn,
    output logic [7:0]        nand_dq_out,
    output logic              nand_dq_oe,
    input  logic [NUM_CE-1:0] nand_rb
);

    localparam int P_CS = (T_CS < 1) ? 1 : T_CS;
    localparam int P_WP = (T_WP < 1) ? 1 : T_WP;
    localparam int P_WH = (T_WH < 1) ? 1 : T_WH;
    localparam int P_WB = (T_WB < 1) ? 1 : T_WB;
    localparam int M_A  = (P_CS > P_WP) ? P_CS : P_WP;
    localparam int M_B  = (P_WH > P_WB) ? P_WH : P_WB;
    localparam int CW   = $clog2((M_A > M_B) ? M_A : M_B) + 1;

    state_t             r_state, w_nxt;
    logic [CW-1:0]      r_cnt;
    logic [39:0]        r_addr;
    logic [2:0]         r_acnt, r_chip;
    logic [7:0]         r_cmd1;
    logic               r_has1, r_wait, r_status;
    logic               w_lo;
    logic [NUM_CE-1:0]  w_rb;
`ifdef NAND_SEQ_TIMEOUT_EN
    logic [31:0]        r_to;
`endif

    nand_rb_sync #(.W(NUM_CE)) u_rb_sync (.i_clk(CLK), .i_rst(RST), .i_rb(nand_rb), .o_rb(w_rb));

    assign nand_wpn = 1'b1;

    // phase that follows any byte's HI period; r_has1 is cleared once cmd1 starts
    always_comb begin
        w_nxt = (r_acnt != 3'd0) ? S_ADDR_LO : r_has1 ? S_CMD1_LO : r_wait ? S_WAIT_WB : S_DONE;
        w_lo  = (w_nxt == S_ADDR_LO) || (w_nxt == S_CMD1_LO);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_acnt      <= '0;
            r_chip      <= '0;
            r_cmd1      <= '0;
            r_has1      <= 1'b0;
            r_wait      <= 1'b0;
            r_status    <= 1'b0;
            req_ready   <= 1'b1;
            done_valid  <= 1'b0;
            done_chip   <= '0;
            done_status <= 1'b0;
            nand_cen    <= '1;
            nand_cle    <= 1'b0;
            nand_ale    <= 1'b0;
            nand_wen    <= 1'b1;
            nand_dq_out <= '0;
            nand_dq_oe  <= 1'b0;
`ifdef NAND_SEQ_TIMEOUT_EN
            r_to        <= '0;
`endif
        end else begin
            done_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_state   <= S_CE_SETUP;
                    r_cnt     <= CW'(P_CS - 1);
                    r_addr    <= req_addr;
                    r_acnt    <= clamp_naddr(req_naddr);
                    r_chip    <= req_chip;
                    r_cmd1    <= req_cmd1;
                    r_has1    <= req_has_cmd1;
                    r_wait    <= req_wait_rb;
                    r_status  <= 1'b0;
                    req_ready <= 1'b0;
                    nand_cen  <= ~(NUM_CE'(1) << req_chip);
                    nand_dq_out <= req_cmd0;
                end
                S_CE_SETUP: if (r_cnt == '0) begin
                    r_state    <= S_CMD0_LO;
                    r_cnt      <= CW'(P_WP - 1);
                    nand_cle   <= 1'b1;
                    nand_dq_oe <= 1'b1;
                    nand_wen   <= 1'b0;
                end else r_cnt <= r_cnt - 1'b1;
                S_CMD0_LO, S_ADDR_LO, S_CMD1_LO: if (r_cnt == '0) begin
                    r_state  <= (r_state == S_CMD0_LO) ? S_CMD0_HI : (r_state == S_ADDR_LO) ? S_ADDR_HI : S_CMD1_HI;
                    r_cnt    <= CW'(P_WH - 1);
                    nand_wen <= 1'b1;
                end else r_cnt <= r_cnt - 1'b1;
                S_CMD0_HI, S_ADDR_HI, S_CMD1_HI: if (r_cnt == '0) begin
                    r_state     <= w_nxt;
                    r_cnt       <= (w_nxt == S_WAIT_WB) ? CW'(P_WB - 1) : CW'(P_WP - 1);
                    nand_cle    <= (w_nxt == S_CMD1_LO);
                    nand_ale    <= (w_nxt == S_ADDR_LO);
                    nand_dq_oe  <= w_lo;
                    nand_wen    <= !w_lo;
                    nand_dq_out <= (w_nxt == S_ADDR_LO) ? r_addr[7:0] : (w_nxt == S_CMD1_LO) ? r_cmd1 : 8'h00;
                    nand_cen    <= (w_nxt == S_DONE) ? '1 : nand_cen;
                    if (w_nxt == S_ADDR_LO) begin
                        r_addr <= r_addr >> 8;
                        r_acnt <= r_acnt - 3'd1;
                    end
                    if (w_nxt == S_CMD1_LO) r_has1 <= 1'b0;
                end else r_cnt <= r_cnt - 1'b1;
                S_WAIT_WB: if (r_cnt == '0) begin
                    r_state <= S_WAIT_RB;
`ifdef NAND_SEQ_TIMEOUT_EN
                    r_to    <= '0;
`endif
                end else r_cnt <= r_cnt - 1'b1;
                S_WAIT_RB: if (w_rb[r_chip]) begin
                    r_state  <= S_DONE;
                    nand_cen <= '1;
                end
`ifdef NAND_SEQ_TIMEOUT_EN
                else if (r_to == 32'(TIMEOUT_CYCLES - 1)) begin
                    r_state  <= S_DONE;
                    r_status <= 1'b1;
                    nand_cen <= '1;
                end else r_to <= r_to + 32'd1;
`endif
                S_DONE: begin
                    r_state     <= S_IDLE;
                    done_valid  <= 1'b1;
                    done_chip   <= r_chip;
                    done_status <= r_status;
                    req_ready   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// tb_nand_cmd_sequencer: directed checks of reset, read, reset-cmd latency, clamp, back-pressure, mid-op reset
module tb_nand_cmd_sequencer;
    import nand_seq_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_chip = '0;
    logic [7:0]  req_cmd0 = '0;
    logic [2:0]  req_naddr = '0;
    logic [39:0] req_addr = '0;
    logic        req_has_cmd1 = 1'b0;
    logic [7:0]  req_cmd1 = '0;
    logic        req_wait_rb = 1'b0;
    logic        done_valid;
    logic [2:0]  done_chip;
    logic        done_status;
    logic [7:0]  nand_cen;
    logic        nand_cle, nand_ale, nand_wen, nand_wpn, nand_dq_oe;
    logic [7:0]  nand_dq_out;
    logic [7:0]  nand_rb = 8'hFF;

    int checks = 0;
    int errs = 0;
    int n_we = 0;
    logic [7:0] cap_dq[16];
    logic       cap_cle[16];
    logic       cap_ale[16];
    logic [7:0] cap_cen[16];

    nand_cmd_sequencer dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_chip(req_chip),
        .req_cmd0(req_cmd0), .req_naddr(req_naddr), .req_addr(req_addr), .req_has_cmd1(req_has_cmd1),
        .req_cmd1(req_cmd1), .req_wait_rb(req_wait_rb), .done_valid(done_valid), .done_chip(done_chip),
        .done_status(done_status), .nand_cen(nand_cen), .nand_cle(nand_cle), .nand_ale(nand_ale),
        .nand_wen(nand_wen), .nand_wpn(nand_wpn), .nand_dq_out(nand_dq_out), .nand_dq_oe(nand_dq_oe),
        .nand_rb(nand_rb)
    );

    always #5 CLK = ~CLK;

    // NAND-side view: what the device latches on every WE# rising edge
    always @(posedge nand_wen) begin
        if (n_we < 16) begin
            cap_dq[n_we]  = nand_dq_out;
            cap_cle[n_we] = nand_cle;
            cap_ale[n_we] = nand_ale;
            cap_cen[n_we] = nand_cen;
        end
        n_we++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [2:0] chip, input logic [7:0] c0, input logic [2:0] na,
                        input logic [39:0] ad, input logic h1, input logic [7:0] c1, input logic wr);
        req_chip = chip; req_cmd0 = c0; req_naddr = na; req_addr = ad;
        req_has_cmd1 = h1; req_cmd1 = c1; req_wait_rb = wr; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        logic found;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < limit) begin
            tick();
            cyc++;
            found = done_valid;
        end
    endtask

    initial begin
        int cyc, bad, cen_bad, pulses, d1, d2;
        logic [7:0] exp_dq[7];
        logic [2:0] chip1, chip2;
        exp_dq = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h30};

        repeat (3) tick();
        check("rst_cen", nand_cen, 8'hFF);
        check("rst_cle", nand_cle, 1'b0);
        check("rst_ale", nand_ale, 1'b0);
        check("rst_wen", nand_wen, 1'b1);
        check("rst_wpn", nand_wpn, 1'b1);
        check("rst_dq", nand_dq_out, 8'h00);
        check("rst_oe", nand_dq_oe, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        check("rst_done", {done_valid, done_chip, done_status}, 5'b0);
        RST = 1'b0;
        tick();

        // reset command: single byte, no wait -> 1+2+4 = 7 cycles
        n_we = 0;
        send(3'd0, CMD_RESET, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0);
        check("rstcmd_ready_low", req_ready, 1'b0);
        wait_done(30, cyc);
        check("rstcmd_latency", cyc, 7);
        check("rstcmd_wen_pulses", n_we, 1);
        check("rstcmd_byte", {cap_cle[0], cap_ale[0], cap_dq[0]}, {2'b10, 8'hFF});
        tick();
        check("rstcmd_done_once", done_valid, 1'b0);

        // page read on chip 2 with busy device
        n_we = 0;
        nand_rb = 8'hFB;
        send(3'd2, CMD_READ0, 3'd5, 40'h0403020100, 1'b1, CMD_READ1, 1'b1);
        bad = 0;
        cen_bad = 0;
        repeat (200) begin
            tick();
            if (done_valid) bad++;
            if (nand_cen !== 8'hFB) cen_bad++;
        end
        check("read_no_early_done", bad, 0);
        check("read_cen_held", cen_bad, 0);
        nand_rb = 8'hFF;
        wait_done(10, cyc);
        check("read_done_seen", done_valid, 1'b1);
        check("read_done_chip", done_chip, 3'd2);
        check("read_done_status", done_status, 1'b0);
        check("read_cen_release", nand_cen, 8'hFF);
        check("read_wen_pulses", n_we, 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("read_dq%0d", i), cap_dq[i], exp_dq[i]);
            check($sformatf("read_cle%0d", i), cap_cle[i], (i == 0 || i == 6));
            check($sformatf("read_ale%0d", i), cap_ale[i], (i != 0 && i != 6));
            check($sformatf("read_cen%0d", i), cap_cen[i], 8'hFB);
        end
        tick();
        check("read_done_once", done_valid, 1'b0);

        // naddr=7 clamps to 5: N=6 -> 1+2+24 = 27 cycles
        n_we = 0;
        send(3'd5, CMD_PROG0, 3'd7, 40'hEEDDCCBBAA, 1'b0, CMD_PROG1, 1'b0);
        wait_done(60, cyc);
        check("clamp_latency", cyc, 27);
        check("clamp_wen_pulses", n_we, 6);
        check("clamp_last_addr", cap_dq[5], 8'hEE);

        // back-pressure: A (chip1, 7 cycles) then B (chip3, erase, N=5 -> 23 cycles)
        send(3'd1, CMD_RESET, 3'd0, 40'h0, 1'b0, 8'h00, 1'b0);
        req_valid = 1'b1;
        req_chip = 3'd3; req_cmd0 = CMD_ERASE0; req_naddr = 3'd3; req_addr = 40'h0000_123456;
        req_has_cmd1 = 1'b1; req_cmd1 = CMD_ERASE1;
        bad = 0; pulses = 0; d1 = 0; d2 = 0; chip1 = '0; chip2 = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c < 7 && req_ready !== 1'b0) bad++;
            if (c == 8) req_valid = 1'b0;
            if (done_valid) begin
                pulses++;
                if (pulses == 1) begin d1 = c; chip1 = done_chip; end
                else begin d2 = c; chip2 = done_chip; end
            end
        end
        check("bp_ready_low", bad, 0);
        check("bp_pulses", pulses, 2);
        check("bp_first_cycle", d1, 7);
        check("bp_first_chip", chip1, 3'd1);
        check("bp_second_cycle", d2, 31);
        check("bp_second_chip", chip2, 3'd3);

        // reset while an address byte is being strobed
        send(3'd4, CMD_READ0, 3'd5, 40'h0403020100, 1'b1, CMD_READ1, 1'b0);
        cyc = 0;
        while (!(nand_ale && !nand_wen) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("midrst_reach_addr", cyc, 6);
        RST = 1'b1;
        tick();
        check("midrst_cen", nand_cen, 8'hFF);
        check("midrst_wen", nand_wen, 1'b1);
        check("midrst_oe", nand_dq_oe, 1'b0);
        check("midrst_cle_ale", {nand_cle, nand_ale}, 2'b00);
        check("midrst_ready", req_ready, 1'b1);
        RST = 1'b0;
        bad = 0;
        repeat (60) begin
            tick();
            if (done_valid) bad++;
        end
        check("midrst_no_done", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end

endmodule

// File: doc/nand_cmd_sequencer.md
Name: nand_cmd_sequencer

Overview:
Per-bus NAND command/address sequencer in the flash controller, directly upstream of the NAND package pins (CEN/CLE/ALE/WEN_NCLK/DQ/RB).
- Accepts one command request: cmd0, 0–5 address bytes, optional cmd1, optional ready/busy wait.
- Drives asynchronous-mode pin waveforms with programmable cycle timing.
- Reports completion to the controller's scheduler.

Parameters:
NUM_CE, 8, chip enables per bus (CEN/RB width)
T_CS, 2, cycles CEN low before first WEN fall
T_WP, 2, cycles WEN held low per byte
T_WH, 2, cycles WEN held high per byte
T_WB, 10, cycles after last WEN rise before sampling RB
TIMEOUT_CYCLES, 1000000, busy-wait limit (optional feature only)

Ports:
CLK  in  1  single clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_chip  in  3  target CE index
req_cmd0  in  8  first command byte
req_naddr  in  3  address byte count 0–5; values >5 clamp to 5
req_addr  in  40  address bytes, [7:0] sent first
req_has_cmd1  in  1  send req_cmd1 after address
req_cmd1  in  8  second command byte
req_wait_rb  in  1  wait for RB high before done
done_valid  out  1  one-cycle completion pulse
done_chip  out  3  chip of completed request
done_status  out  1  0 ok, 1 timeout
nand_cen  out  NUM_CE  active-low chip enables
nand_cle  out  1  command latch enable
nand_ale  out  1  address latch enable
nand_wen  out  1  WE#/CLK shared pin
nand_wpn  out  1  write protect, constant 1 after reset
nand_dq_out  out  8  DQ drive value
nand_dq_oe  out  1  DQ tristate enable
nand_rb  in  NUM_CE  ready/busy, async, 1 = ready

Behaviour:
- Reset values:
  - nand_cen all 1; nand_cle 0; nand_ale 0; nand_wen 1; nand_wpn 1; nand_dq_out 0; nand_dq_oe 0.
  - req_ready 1; done_valid 0; done_chip 0; done_status 0.
  - FSM in IDLE; all counters 0.
- Accept: in IDLE, a request is taken when req_valid && req_ready. All request fields are latched at that edge.
- States:
  - IDLE → CE_SETUP: cen[chip]=0 for T_CS cycles.
  - CMD0_LO/CMD0_HI: cle=1, dq=cmd0, oe=1. wen=0 for T_WP cycles, then wen=1 for T_WH cycles.
  - ADDR_LO/ADDR_HI: repeated naddr times. ale=1, dq=next address byte. naddr=0 skips the address phase.
  - CMD1_LO/CMD1_HI: only if has_cmd1. Same waveform as CMD0, dq=cmd1.
  - Then: if wait_rb → WAIT_WB (T_WB cycles) → WAIT_RB; else → DONE.
  - WAIT_RB: exits to DONE when 2-flop-synchronized rb[chip]==1.
  - DONE: cen all 1, cle/ale 0, oe 0, done_valid=1 for exactly one cycle, then IDLE.
- Byte timing:
  - cle/ale/dq stay stable for the whole LO+HI period of each byte, so the NAND latches on the wen rising edge with T_WH hold.
  - cle and ale are never both 1.
- Latency, wait_rb=0: done_valid asserts exactly 1+T_CS+N*(T_WP+T_WH) cycles after the accept edge, where N = 1 + naddr + has_cmd1.
- req_ready is 0 from the accept edge until the cycle after DONE. req_valid while busy is ignored and is not queued.
- RB already high on entry to WAIT_RB (after T_WB) → DONE next cycle. RB glitches during WAIT_WB are ignored.
- RST mid-operation: returns to reset values at the next edge; no done pulse.
- Counters: width $clog2(max param)+1; each loads param−1 on state entry. A parameter value of 0 is treated as 1.

Optional Feature:
- Macro: NAND_SEQ_TIMEOUT_EN.
- Defined: 32-bit counter runs in WAIT_RB. On reaching TIMEOUT_CYCLES it goes to DONE with done_status=1.
- Undefined: no counter; WAIT_RB waits indefinitely and done_status is always 0.

Decomposition:
- Package nand_seq_pkg holds:
  - FSM state enum.
  - Opcode constants: CMD_RESET=8'hFF, CMD_READ0=8'h00, CMD_READ1=8'h30, CMD_PROG0=8'h80, CMD_PROG1=8'h10, CMD_ERASE0=8'h60, CMD_ERASE1=8'hD0.
  - MAX_ADDR_BYTES=5.
- Sub-module nand_rb_sync: NUM_CE-wide 2-flop synchronizer for nand_rb.

Test Plan:
- Reset: RST high 3 cycles → all outputs at reset values; req_ready=1.
- Read: cmd0=00h, naddr=5, addr=40'h0403020100, cmd1=30h, wait_rb=1, chip 2; model holds RB low 200 cycles → exactly 7 wen rising edges, byte sequence 00,00,01,02,03,04,30. cle high only on bytes 1 and 7, cen[2] low throughout. done_valid pulses once after RB rises, status 0.
- Reset command: FFh, naddr=0, has_cmd1=0, wait_rb=0, defaults → one wen pulse; done_valid exactly 7 cycles after accept.
- Back-pressure: req_valid held high while busy → req_ready 0; second request accepted the cycle after DONE; no lost or duplicate done pulses.
- Mid-op reset: RST asserted during ADDR_LO → next edge cen=FF, wen=1, oe=0; no done_valid.
- Timeout (NAND_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=50): RB stuck low → done_valid with done_status=1 at 50 cycles into WAIT_RB.
